cmsdk_apb3_eg_master_interface: RTL

//  APB3 initiator (requester): converts a simple valid/ready register request port into APB3

---
 rtl/cmsdk_apb3_eg_master_interface.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cmsdk_apb3_eg_master_interface.sv
// APB3 requester: turns a valid/ready register request into an APB3 SETUP/ACCESS transfer
// and returns read data and slave error through a one-entry response register.
module cmsdk_apb3_eg_master_interface #(
  parameter int ADDRWIDTH = 12,
  parameter int TIMEOUT   = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 timeout,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [ADDRWIDTH-1:0] paddr,
  output logic [31:0]          pwdata,
  input  logic [31:0]          prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam bit         TIMEOUT_EN  = (TIMEOUT != 0);

  logic [1:0]           state_reg,     state_next;
  logic                 psel_reg,      psel_next;
  logic                 penable_reg,   penable_next;
  logic                 pwrite_reg,    pwrite_next;
  logic [ADDRWIDTH-1:0] paddr_reg,     paddr_next;
  logic [31:0]          pwdata_reg,    pwdata_next;
  logic                 rsp_valid_reg, rsp_valid_next;
  logic [31:0]          rsp_rdata_reg, rsp_rdata_next;
  logic                 rsp_err_reg,   rsp_err_next;
  logic [7:0]           wait_cnt_reg,  wait_cnt_next;
  logic [31:0]          rdata_masked;
  logic                 accept;

  // Writes return zero data, so the slave's read bus is masked off by direction.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rdata_mask
      assign rdata_masked[gi] = prdata[gi] & ~pwrite_reg;
    end
  endgenerate

  // A request is only taken when the response slot is empty or being drained this edge.
  assign req_ready = (state_reg == ST_IDLE) && (!rsp_valid_reg || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_next     = state_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    wait_cnt_next  = wait_cnt_reg;

    if (rsp_valid_reg && rsp_ready) begin
      rsp_valid_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          paddr_next    = req_addr;
          pwdata_next   = req_wdata;
          pwrite_next   = req_write;
          psel_next     = 1'b1;
          penable_next  = 1'b0;
          wait_cnt_next = 8'd0;
          state_next    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_next = 1'b1;
        state_next   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = rdata_masked;
          rsp_err_next   = pslverr;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          state_next     = ST_IDLE;
        end else if (wait_cnt_reg != 8'hFF) begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      default: begin
        psel_next    = 1'b0;
        penable_next = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_reg     <= ST_IDLE;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= 32'd0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
      wait_cnt_reg  <= 8'd0;
    end else begin
      state_reg     <= state_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      wait_cnt_reg  <= wait_cnt_next;
    end
  end

  // Timeout is advisory only; the transfer keeps waiting for pready.
  assign timeout   = TIMEOUT_EN && (state_reg == ST_ACCESS) && (wait_cnt_reg >= TIMEOUT_CNT);

  assign psel      = psel_reg;
  assign penable   = penable_reg;
  assign pwrite    = pwrite_reg;
  assign paddr     = paddr_reg;
  assign pwdata    = pwdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule
